booth_seq_multiplier: RTL

- Sequential radix-2 Booth signed multiplier for the arithmetic unit.
- Each iteration issues one add, subtract or no-op against the partial product, so it drives the n-bit add/subtract path.
- Produces a 2N-bit two's-complement product one iteration per cycle.
- Uses a start/done handshake so a datapath controller can issue multiplies back-to-back.

---
 rtl/booth_seq_multiplier.sv | 139 +++++++++++++
 1 files changed

// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: radix-2 Booth signed multiplier, one iteration per cycle.
// Ports: clk, rst_n (sync, active-low), start, multiplicand, multiplier
//        -> busy, done (1-cycle pulse), product (2N bits, held between results).
// Optional: define BOOTH_OVF_EN to add output ovf (product not representable
//           as an N-bit signed value), updated alongside product.
module booth_seq_multiplier #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
`ifdef BOOTH_OVF_EN
    ,
    output logic           ovf
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int CW = $clog2(N + 1);
    localparam logic [N:0] ONE = (N + 1)'(1);

    state_t         state_q, state_d;
    logic [N:0]     m_q, m_d;
    logic [N:0]     a_q, a_d;
    logic [N-1:0]   qr_q, qr_d;
    logic           q1_q, q1_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] prod_q, prod_d;
    logic           done_q, done_d;

    logic [N:0]     sum;
    logic [N:0]     a_sh;
    logic [N-1:0]   q_sh;
    logic [2*N-1:0] full_p;
    logic           fin;

    // A is one bit wider than M so that A - (-2^(N-1)) cannot overflow.
    always_comb begin
        sum = a_q;
        unique case ({qr_q[0], q1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q + ~m_q + ONE;
            default: sum = a_q;
        endcase
    end

    // Arithmetic shift right of {A, Q, Q_1}.
    assign a_sh   = {sum[N], sum[N:1]};
    assign q_sh   = {sum[0], qr_q[N-1:1]};
    assign full_p = {a_sh[N-1:0], q_sh};
    assign fin    = (state_q == RUN) && (cnt_q == CW'(1));

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        qr_d    = qr_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = {multiplicand[N-1], multiplicand};
                    a_d     = '0;
                    qr_d    = multiplier;
                    q1_d    = 1'b0;
                    cnt_d   = CW'(N);
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_sh;
                qr_d  = q_sh;
                q1_d  = qr_q[0];
                cnt_d = cnt_q - CW'(1);
                if (fin) begin
                    prod_d  = full_p;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            a_q     <= '0;
            qr_q    <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            qr_q    <= qr_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign product = prod_q;

`ifdef BOOTH_OVF_EN
    logic       ovf_q, ovf_d;
    logic [N:0] top;

    // Fits in N signed bits only if the upper N+1 bits are all sign copies.
    assign top = full_p[2*N-1:N-1];

    always_comb begin
        ovf_d = ovf_q;
        if (fin) ovf_d = ~((&top) | (~|top));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

endmodule
